// File: rtl/nonce_result_scanner_pkg.sv
// Shared definitions for the nonce result scanner.
//
// Purpose : state encoding, memory interface widths, summary word layout
//           and the initial value of the running minimum.
// Ports   : none (package).
package nonce_result_scanner_pkg;

    // Memory interface widths, common to the hasher and the scanner.
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    // Summary word layout: {found, zero padding, best_nonce}.
    localparam int FOUND_BIT = 31;

    // Running minimum starts at the largest hash so the first sample wins.
    localparam logic [MEM_DATA_W-1:0] BEST_HASH_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/nonce_result_scanner_min_tracker.sv
// Registered compare/select that tracks the smallest hash seen in a scan.
//
// Purpose : keeps best_hash/best_nonce (strictly smaller replaces, so on a
//           tie the earlier, lower nonce is kept) and a sticky found flag
//           (set when any hash is below target).
// Ports   : clk, reset_n     - clock, async active-low reset
//           clr_i            - restart tracking (load initial values)
//           valid_i          - hash_i/idx_i carry a sample this cycle
//           idx_i, hash_i    - nonce index and its hash
//           target_i         - difficulty threshold (unsigned compare)
//           best_hash_o, best_nonce_o, found_o - registered results
module nonce_result_scanner_min_tracker
    import nonce_result_scanner_pkg::*;
#(
    parameter int NONCE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  valid_i,
    input  logic [NONCE_W-1:0]    idx_i,
    input  logic [MEM_DATA_W-1:0] hash_i,
    input  logic [MEM_DATA_W-1:0] target_i,
    output logic [MEM_DATA_W-1:0] best_hash_o,
    output logic [NONCE_W-1:0]    best_nonce_o,
    output logic                  found_o
);

    logic [MEM_DATA_W-1:0] best_hash_q, best_hash_d;
    logic [NONCE_W-1:0]    best_nonce_q, best_nonce_d;
    logic                  found_q, found_d;

    always_comb begin
        best_hash_d  = best_hash_q;
        best_nonce_d = best_nonce_q;
        found_d      = found_q;
        if (clr_i) begin
            best_hash_d  = BEST_HASH_INIT;
            best_nonce_d = '0;
            found_d      = 1'b0;
        end else if (valid_i) begin
            // Strict less-than: equal hashes keep the earlier nonce.
            if (hash_i < best_hash_q) begin
                best_hash_d  = hash_i;
                best_nonce_d = idx_i;
            end
            if (hash_i < target_i) begin
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_hash_q  <= BEST_HASH_INIT;
            best_nonce_q <= '0;
            found_q      <= 1'b0;
        end else begin
            best_hash_q  <= best_hash_d;
            best_nonce_q <= best_nonce_d;
            found_q      <= found_d;
        end
    end

    assign best_hash_o  = best_hash_q;
    assign best_nonce_o = best_nonce_q;
    assign found_o      = found_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Nonce result scanner: reads back NUM_NONCES hash words from memory,
// picks the smallest (lowest nonce on ties), flags whether any hash is
// below target, and writes a one-word summary to result_addr.
//
// Ports   : clk, reset_n              - clock, async active-low reset
//           start                     - begin a scan (sampled only in IDLE)
//           hash_out_addr             - word address of the hash for nonce 0
//           result_addr               - word address of the summary word
//           target                    - difficulty threshold
//           done                      - high while idle
//           mem_clk, mem_we, memory_addr, memory_write_data,
//           memory_read_data          - single-port synchronous memory
//           found, best_nonce, best_hash - result of the last scan
//           dbg_state                 - current FSM state (state_t encoding)
//
// Handshake: start is a level sampled on each rising edge while done=1; the
// edge that sees start=1 in IDLE accepts the scan and done drops in the next
// cycle. start while done=0 is ignored, never queued. done returns high
// NUM_NONCES+3 cycles after the accepting edge, by which time the summary
// word has been written (mem_we high for exactly one cycle, the last busy one).
module nonce_result_scanner
    import nonce_result_scanner_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] hash_out_addr,
    input  logic [MEM_ADDR_W-1:0] result_addr,
    input  logic [MEM_DATA_W-1:0] target,
    output logic                  done,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] memory_addr,
    output logic [MEM_DATA_W-1:0] memory_write_data,
    input  logic [MEM_DATA_W-1:0] memory_read_data,
    output logic                  found,
    output logic [NONCE_W-1:0]    best_nonce,
    output logic [MEM_DATA_W-1:0] best_hash,
    output logic [1:0]            dbg_state
);

    localparam int              CNT_W    = NONCE_W + 1;
    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NONCES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        cap_cnt_q, cap_cnt_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    // Low in the first READ cycle: the first read data only arrives one
    // cycle later, so capture starts from the second READ cycle.
    logic                    primed_q, primed_d;
    logic                    trk_clr;
    logic                    trk_valid;
    logic [MEM_DATA_W-1:0]   summary;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        addr_d      = addr_q;
        primed_d    = primed_q;
        trk_clr     = 1'b0;
        trk_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    addr_d      = hash_out_addr;
                    issue_cnt_d = CNT_W'(1);
                    cap_cnt_d   = '0;
                    primed_d    = 1'b0;
                    trk_clr     = 1'b1;
                end
            end

            READ: begin
                // Address issue runs one cycle ahead of capture; the 16-bit
                // sum wraps naturally past 16'hFFFF.
                if (issue_cnt_q < NUM_CNT) begin
                    addr_d      = hash_out_addr + MEM_ADDR_W'(issue_cnt_q);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                primed_d = 1'b1;
                if (primed_q) begin
                    trk_valid = 1'b1;
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    if (cap_cnt_q == LAST_CNT) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            addr_q      <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            addr_q      <= addr_d;
            primed_q    <= primed_d;
        end
    end

    // ------------------------------------------------------------------
    // Running minimum
    // ------------------------------------------------------------------
    nonce_result_scanner_min_tracker #(
        .NONCE_W (NONCE_W)
    ) u_min_tracker (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (trk_clr),
        .valid_i      (trk_valid),
        .idx_i        (cap_cnt_q[NONCE_W-1:0]),
        .hash_i       (memory_read_data),
        .target_i     (target),
        .best_hash_o  (best_hash),
        .best_nonce_o (best_nonce),
        .found_o      (found)
    );

    // ------------------------------------------------------------------
    // Memory port and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        summary                = '0;
        summary[NONCE_W-1:0]   = best_nonce;
        summary[FOUND_BIT]     = found;
    end

    // Write-side signals decode straight from the state register, so an
    // asynchronous reset drops mem_we in the same cycle.
    assign mem_clk           = clk;
    assign done              = (state_q == IDLE);
    assign mem_we            = (state_q == WRITE);
    assign memory_addr       = (state_q == WRITE) ? result_addr : addr_q;
    assign memory_write_data = (state_q == WRITE) ? summary : '0;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed testbench for nonce_result_scanner (NUM_NONCES=16, NONCE_W=8).
module tb_nonce_result_scanner;

    localparam int N = 16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] hash_out_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        found;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    nonce_result_scanner #(
        .NUM_NONCES (N),
        .NONCE_W    (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .hash_out_addr     (hash_out_addr),
        .result_addr       (result_addr),
        .target            (target),
        .done              (done),
        .mem_clk           (mem_clk),
        .mem_we            (mem_we),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .found             (found),
        .best_nonce        (best_nonce),
        .best_hash         (best_hash),
        .dbg_state         (dbg_state)
    );

    // ---------------- memory model ----------------
    // Synchronous read; DUT writes are recorded rather than stored.
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    int          wr_count = 0;
    logic [15:0] wr_addr_last = '0;
    logic [31:0] wr_data_last = '0;

    always @(posedge clk) begin
        rd_q <= mem[memory_addr];
        if (mem_we) begin
            wr_count     <= wr_count + 1;
            wr_addr_last <= memory_addr;
            wr_data_last <= memory_write_data;
        end
    end
    assign memory_read_data = rd_q;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic put_hash(input logic [15:0] base, input int idx, input logic [31:0] val);
        logic [15:0] a;
        a = base + 16'(idx);
        mem[a] = val;
    endtask

    // Pulses start, then watches each cycle until done rises. Cycle 1 is the
    // first cycle after the accepting edge. mid_start>0 drives start high
    // during that cycle to probe that a busy scanner ignores it.
    task automatic run_scan(input int mid_start, output int done_cyc, output int we_cyc,
                            output int we_n, output logic [15:0] we_addr, output logic fell);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        fell     = !done;
        done_cyc = -1;
        we_cyc   = -1;
        we_n     = 0;
        we_addr  = '0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (mem_we) begin
                we_n++;
                we_cyc  = cyc;
                we_addr = memory_addr;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == mid_start);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic scan_and_check(input string tag, input int mid_start,
                                  input logic [7:0] exp_nonce, input logic [31:0] exp_hash,
                                  input logic exp_found, input logic [31:0] exp_sum);
        int done_cyc, we_cyc, we_n, wr_before;
        logic [15:0] we_addr;
        logic fell;
        wr_before = wr_count;
        run_scan(mid_start, done_cyc, we_cyc, we_n, we_addr, fell);
        check({tag, "_done_fell"}, 32'(fell), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(N + 3));
        check({tag, "_we_cycle"}, 32'(we_cyc), 32'(N + 2));
        check({tag, "_we_count"}, 32'(we_n), 32'd1);
        check({tag, "_we_addr"}, 32'(we_addr), 32'(result_addr));
        check({tag, "_best_nonce"}, 32'(best_nonce), 32'(exp_nonce));
        check({tag, "_best_hash"}, best_hash, exp_hash);
        check({tag, "_found"}, 32'(found), 32'(exp_found));
        check({tag, "_mem_writes"}, 32'(wr_count - wr_before), 32'd1);
        check({tag, "_summary_addr"}, 32'(wr_addr_last), 32'(result_addr));
        check({tag, "_summary"}, wr_data_last, exp_sum);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr_before;
        reset_n       = 1'b0;
        start         = 1'b0;
        hash_out_addr = '0;
        result_addr   = '0;
        target        = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_done", 32'(done), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(memory_addr), 32'd0);
        check("rst_wdata", memory_write_data, 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_best_nonce", 32'(best_nonce), 32'd0);
        check("rst_best_hash", best_hash, 32'hFFFF_FFFF);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ascending 100..115, nothing below target 50
        hash_out_addr = 16'h0100; result_addr = 16'h0200; target = 32'd50;
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'(100 + i));
        scan_and_check("asc", 0, 8'd0, 32'd100, 1'b0, 32'h0000_0000);

        // Descending 115..100, target 105
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'(115 - i));
        target = 32'd105;
        scan_and_check("desc", 0, 8'd15, 32'd100, 1'b1, 32'h8000_000F);

        // Tie between nonces 3 and 9: lower nonce wins
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'hFFFF_0000);
        put_hash(hash_out_addr, 3, 32'h0000_0010);
        put_hash(hash_out_addr, 9, 32'h0000_0010);
        target = 32'h20;
        scan_and_check("tie", 0, 8'd3, 32'h10, 1'b1, 32'h8000_0003);

        // All hashes at the maximum: initial minimum is never replaced
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'hFFFF_FFFF);
        target = 32'hFFFF_FFFF;
        scan_and_check("allmax", 0, 8'd0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000);

        // Reset during READ (cycle 7): no summary write, reset values back
        hash_out_addr = 16'h0300; result_addr = 16'h0400; target = 32'd5;
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'(1000 + i));
        put_hash(hash_out_addr, 11, 32'd7);
        wr_before = wr_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_busy", 32'(done), 32'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_addr", 32'(memory_addr), 32'd0);
        check("midrst_best_hash", best_hash, 32'hFFFF_FFFF);
        check("midrst_best_nonce", 32'(best_nonce), 32'd0);
        check("midrst_found", 32'(found), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("midrst_no_write", 32'(wr_count - wr_before), 32'd0);
        check("midrst_idle", 32'(done), 32'd1);
        scan_and_check("postrst", 0, 8'd11, 32'd7, 1'b0, 32'h0000_000B);

        // Address wrap past 16'hFFFF, target 0, start pulsed mid-scan
        hash_out_addr = 16'hFFFA; result_addr = 16'h0500; target = 32'd0;
        for (int i = 0; i < N; i++) put_hash(hash_out_addr, i, 32'(2000 + i));
        put_hash(hash_out_addr, 9, 32'd50);
        scan_and_check("wrap", 5, 8'd9, 32'd50, 1'b0, 32'h0000_0009);
        @(negedge clk);
        check("wrap_not_queued", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
